lcd_write_sink: RTL and testbench

Display-side consumer of the processor's `lcd_write`/`lcd_data` output port. It buffers each character or command the processor writes in a small FIFO. It runs the HD44780 power-up and initialisation sequence, then replays the buffered bytes onto an 8-bit character-LCD bus with correct enable-pulse and execution timing. It sits beside the processor at top level, between the core and the board's LCD pins.

---
 rtl/lcd_write_sink.sv | 158 +++++++++++++++
 tb/tb_lcd_write_sink.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sink.sv
// Buffers processor LCD writes in a FIFO, runs the HD44780 power-up/init sequence,
// then replays bytes onto an 8-bit LCD bus. Optional `LCD_CURSOR_TRACK_EN: 16x2 line wrap.
module lcd_write_sink #(
  parameter int T_POWERUP  = 1000000,
  parameter int T_EN       = 16,
  parameter int T_CHAR     = 2500,
  parameter int T_CLEAR    = 100000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lcd_write,
  input  logic [31:0] lcd_data,
  output logic        lcd_full,
  output logic        lcd_ready,
  output logic        lcd_overflow,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_db,
  output logic        lcd_on
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0]  C_PWR   = 32'(T_POWERUP - 1);
  localparam logic [31:0]  C_EN    = 32'(T_EN - 1);
  localparam logic [31:0]  C_CHR   = 32'(T_CHAR - 1);
  localparam logic [31:0]  C_CLR   = 32'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_cnt;
  logic [1:0]    r_idx;
  logic [8:0]    r_byte;
  logic          r_ready, r_en, r_rs, r_ovf;
  logic [7:0]    r_db;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [8:0]    w_head;
  logic          w_push, w_pop, w_ins, w_is_clr, w_wait_done;
  logic [7:0]    w_ins_byte;
  logic          w_unused;

  assign w_unused = ^lcd_data[31:9];

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign w_head      = r_mem[r_rd];
  assign w_is_clr    = r_byte[8] && (r_byte[7:0] == 8'h01 || r_byte[7:0] == 8'h02);
  assign w_wait_done = (r_cnt == (w_is_clr ? C_CLR : C_CHR));
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !w_ins;
  assign w_push      = lcd_write && ((r_count != DEPTH_C) || w_pop);

`ifdef LCD_CURSOR_TRACK_EN
  logic       r_line;
  logic [4:0] r_col;

  // A full line is wrapped lazily: the jump command goes out only once another data byte is due.
  assign w_ins      = (r_state == S_IDLE) && (r_count != '0) && !w_head[8] && (r_col == 5'd16);
  assign w_ins_byte = r_line ? 8'h80 : 8'hC0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_line <= 1'b0;
      r_col  <= '0;
    end else if (r_state == S_IDLE && r_count != '0) begin
      if (w_ins) begin
        r_line <= ~r_line;
        r_col  <= '0;
      end else if (!w_head[8]) begin
        r_col <= r_col + 5'd1;
      end else if (w_head[7:0] == 8'h01 || w_head[7:0] == 8'h02) begin
        r_line <= 1'b0;
        r_col  <= '0;
      end
    end
  end
`else
  assign w_ins      = 1'b0;
  assign w_ins_byte = 8'h00;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PWR:   if (r_cnt == C_PWR) w_next = S_INIT;
      S_INIT:  w_next = S_SETUP;
      S_IDLE:  if (r_count != '0) w_next = S_SETUP;
      S_SETUP: w_next = S_PULSE;
      S_PULSE: if (r_cnt == C_EN) w_next = S_HOLD;
      S_HOLD:  w_next = S_WAIT;
      S_WAIT:  if (w_wait_done) w_next = (!r_ready && r_idx != 2'd3) ? S_INIT : S_IDLE;
      default: w_next = S_PWR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_PWR;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_db    <= '0;
      r_ovf   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
      if (r_state == S_INIT)
        r_byte <= {1'b1, init_byte(r_idx)};
      else if (r_state == S_IDLE && r_count != '0)
        r_byte <= w_ins ? {1'b1, w_ins_byte} : w_head;
      // Pins trail the FSM by one edge so the bus settles a cycle before enable rises.
      if (r_state == S_SETUP) begin
        r_db <= r_byte[7:0];
        r_rs <= ~r_byte[8];
      end
      r_en <= (r_state == S_PULSE);
      if (r_state == S_WAIT && w_wait_done && !r_ready) begin
        if (r_idx == 2'd3) r_ready <= 1'b1;
        else               r_idx   <= r_idx + 2'd1;
      end
      if (w_push) begin
        r_mem[r_wr] <= lcd_data[8:0];
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (lcd_write && !w_push) r_ovf <= 1'b1;
    end
  end

  assign lcd_full     = (r_count == DEPTH_C);
  assign lcd_ready    = r_ready;
  assign lcd_overflow = r_ovf;
  assign lcd_en       = r_en;
  assign lcd_rs       = r_rs;
  assign lcd_db       = r_db;
  assign lcd_rw       = 1'b0;
  assign lcd_on       = 1'b1;
endmodule

// File: tb/tb_lcd_write_sink.sv
// Scoreboard bench for lcd_write_sink: expected {rs,db} queued at write time,
// popped on each lcd_en rising edge; also checks pulse width, setup/hold and gaps.
module tb_lcd_write_sink;
  localparam int T_POWERUP = 20, T_EN = 2, T_CHAR = 5, T_CLEAR = 10, DEPTH = 4;
  localparam int READY_LAT = T_POWERUP + 4*(T_EN+3) + 3*T_CHAR + T_CLEAR;

  logic        clock, reset, lcd_write;
  logic [31:0] lcd_data;
  logic        lcd_full, lcd_ready, lcd_overflow, lcd_en, lcd_rs, lcd_rw, lcd_on;
  logic [7:0]  lcd_db;

  lcd_write_sink #(.T_POWERUP(T_POWERUP), .T_EN(T_EN), .T_CHAR(T_CHAR),
                   .T_CLEAR(T_CLEAR), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .lcd_write(lcd_write), .lcd_data(lcd_data),
    .lcd_full(lcd_full), .lcd_ready(lcd_ready), .lcd_overflow(lcd_overflow),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_on(lcd_on));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_vec = 0, n_err = 0, cyc = 0, rel_cyc = 0;
  logic [8:0] sb[$];
  int         rise_q[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Pin monitor
  logic       m_prev_en = 1'b0;
  logic [8:0] m_prev_bus = '0, m_rise_bus = '0;
  int         m_w = 0;
  always @(negedge clock) begin
    if (reset) begin
      m_prev_en = 1'b0;
      m_w = 0;
    end else begin
      if (lcd_en && !m_prev_en) begin
        rise_q.push_back(cyc);
        chk("setup_db", {lcd_rs, lcd_db}, m_prev_bus);
        if (sb.size() == 0) chk("unexp_pulse", sb.size(), 1);
        else                chk("byte", {lcd_rs, lcd_db}, sb.pop_front());
        m_rise_bus = {lcd_rs, lcd_db};
        m_w = 0;
      end
      if (lcd_en) m_w++;
      if (!lcd_en && m_prev_en) begin
        chk("en_width", m_w, T_EN);
        chk("hold_db", {lcd_rs, lcd_db}, m_rise_bus);
      end
      m_prev_en = lcd_en;
    end
    m_prev_bus = {lcd_rs, lcd_db};
  end

  task automatic push_init();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; lcd_write = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_outs", {lcd_en, lcd_rs, lcd_rw, lcd_db, lcd_on, lcd_ready, lcd_full, lcd_overflow},
        {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    rel_cyc = cyc;
    sb.delete(); rise_q.delete();
    push_init();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!lcd_ready && n < 500) begin @(negedge clock); n++; end
    chk("ready", lcd_ready, 1);
    chk("ready_lat", cyc - rel_cyc, READY_LAT);
  endtask

  task automatic wr(input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    while (lcd_full && n < 500) begin @(negedge clock); n++; end
    lcd_write = 1'b1; lcd_data = d;
    sb.push_back({~d[8], d[7:0]});
    @(negedge clock);
    lcd_write = 1'b0; lcd_data = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clock); n++; end
    repeat (40) @(negedge clock);
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!lcd_en && n < 300) begin @(negedge clock); n++; end
    chk("wait_en", lcd_en, 1);
  endtask

  initial begin
    reset = 1'b1; lcd_write = 1'b0; lcd_data = '0;

    // Init sequence and its pulse spacing
    do_reset();
    wait_ready();
    chk("init_pulses", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      chk("gap_38_0c", rise_q[1] - rise_q[0], T_EN + 3 + T_CHAR);
      chk("gap_0c_01", rise_q[2] - rise_q[1], T_EN + 3 + T_CHAR);
      chk("gap_01_06", rise_q[3] - rise_q[2], T_EN + 3 + T_CLEAR);
    end
    drain();

    // Single data write, then clear command followed by data
    rise_q.delete();
    wr(32'h0000_0041);
    drain();
    wr(32'h0000_0101);
    wr(32'hABCD_0043);
    drain();
    chk("cmd_pulses", rise_q.size(), 3);
    if (rise_q.size() == 3) chk("gap_clear", rise_q[2] - rise_q[1], T_EN + 3 + T_CLEAR);

    // Writes during PWR_WAIT drain after init
    do_reset();
    wr(32'h0000_0141);
    wr(32'hFFFF_FE42);
    wait_ready();
    drain();

    // Overflow with the engine busy
    rise_q.delete();
    wr(32'h0000_0030);
    wait_en();
    for (int i = 0; i < 6; i++) begin
      lcd_write = 1'b1; lcd_data = 32'h60 + i;
      if (i < DEPTH) sb.push_back({1'b1, 8'h60 + 8'(i)});
      @(negedge clock);
      if (i == DEPTH - 1) chk("full_at_4", {lcd_full, lcd_overflow}, 2'b10);
    end
    lcd_write = 1'b0;
    chk("ovf_set", {lcd_full, lcd_overflow}, 2'b11);
    drain();
    chk("ovf_sticky", lcd_overflow, 1);
    chk("full_clr", lcd_full, 0);
    chk("ovf_pulses", rise_q.size(), 5);
    for (int i = 1; i < rise_q.size(); i++) chk("byte_period", rise_q[i] - rise_q[i-1], T_EN + T_CHAR + 3);

    // Reset while enable is high; FIFO contents must vanish
    wr(32'h50); wr(32'h51); wr(32'h52);
    wait_en();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_outs", {lcd_en, lcd_rs, lcd_db, lcd_ready, lcd_full, lcd_overflow}, 13'h0);
    reset = 1'b0;
    rel_cyc = cyc;
    sb.delete(); rise_q.delete();
    push_init();
    wait_ready();
    drain();

    // 17 data bytes: line wrap command only when tracking is built
    for (int i = 0; i < 17; i++) begin
      wr(32'h41 + i);
`ifdef LCD_CURSOR_TRACK_EN
      if (i == 15) sb.push_back({1'b0, 8'hC0});
`endif
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
